sqrt_lut_arbiter: RTL and testbench
===================================

Name: sqrt_lut_arbiter

Overview:
Shares one pipelined SqrtLut instance (16-bit in, 8-bit out, fixed latency) between NREQ independent requesters. It uses round-robin arbitration and allows at most one outstanding operation per requester. A tag pipeline matched to the LUT latency routes each result back to the requester that issued it. The block sits between the pixel/magnitude producers and the single shared SqrtLut.

Parameters:
NREQ, 4, number of requesters (2..8)
LUT_LAT, 2, SqrtLut latency in cycles from val_i sampled high to val_o high
TAG_W, 2, tag width; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_data  input  NREQ*16  radicands, requester r at bits [16r+15:16r]
res_valid  output  NREQ  per-requester result valid
res_ready  input  NREQ  per-requester result consume
res_data  output  NREQ*8  results, requester r at bits [8r+7:8r]
lut_i  output  16  to SqrtLut sqrt_lut_i
lut_val_i  output  1  to SqrtLut val_i
lut_o  input  8  from SqrtLut sqrt_lut_o
lut_val_o  input  1  from SqrtLut val_o
err  output  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync release): req_ready=0, lut_i=0, lut_val_i=0, res_valid=0, res_data=0, err=0. busy[] cleared, rr pointer=0, tag pipeline cleared, guard counter loaded with LUT_LAT+1.
- Eligibility: requester r is eligible when req_valid[r] && !busy[r].
- Arbitration (combinational): at most one grant per cycle. Search starts at rr pointer and goes upward modulo NREQ; first eligible wins.
- req_ready[g] is high only for the granted requester. Handshake completes on req_valid && req_ready at the rising edge.
- On handshake at edge T:
  - lut_i <= req_data[g]; lut_val_i <= 1; busy[g] <= 1; rr <= (g+1) mod NREQ.
  - Tag g enters the tag pipeline with valid=1.
- No grant: lut_val_i <= 0, lut_i holds its value, rr holds.
- Tag pipeline is LUT_LAT+1 stages deep, so the tag emerges aligned with lut_val_o.
- Result capture: when lut_val_o=1 and the tag at the pipeline output is valid, res_data[tag] <= lut_o and res_valid[tag] <= 1.
- Latency: request handshake at edge T, then lut_val_i high in cycle T+1, lut_val_o in cycle T+1+LUT_LAT, res_valid high in cycle T+2+LUT_LAT. With LUT_LAT=2 this is 4 cycles.
- Result hold: res_valid[r] and res_data[r] hold until res_valid[r] && res_ready[r] at an edge. Then res_valid[r] <= 0 and busy[r] <= 0.
- Re-grant after pop: eligibility uses the registered busy, so r can be granted no earlier than the cycle after its pop.
- Because of the single-outstanding rule, a result slot never overflows; no result backpressure reaches the LUT.
- Unmatched val_o: lut_val_o=1 with no valid tag, or tag valid with lut_val_o=0, is dropped and sets err=1.
  - Exception: while the guard counter is nonzero, mismatches are ignored. This covers stale LUT outputs after a reset mid-operation, since the LUT itself has no reset.
  - The guard counter decrements every cycle to 0.
  - err clears only on reset.
- Reset mid-operation: in-flight operations are abandoned, all busy bits clear, and no res_valid is raised for them.
- Full throughput: with all NREQ requesters popping immediately, the LUT accepts one operation per cycle as long as NREQ >= LUT_LAT+3.

Test Plan:
- Single request: requester 0 issues 0x0100 at edge T (LUT_LAT=2) -> lut_val_i high in cycle T+1 with lut_i=0x0100; res_valid[0] high in cycle T+4 with res_data[0]=0x10; err=0.
- All four requesters valid at once with 0x0100/0x0400/0x0900/0x1000, rr=0 -> grants 0,1,2,3 on consecutive cycles; results 0x10,0x20,0x30,0x40 on the matching res_data.
- Backpressure: res_ready[1]=0 for 10 cycles while req_valid[1] stays high -> req_ready[1] stays 0 and res_data[1] is stable. Pop at edge P -> res_valid[1] falls, and the next grant for 1 occurs no earlier than cycle P+1.
- Fairness: requesters 0 and 2 continuously valid with immediate pops -> grants alternate 0,2,0,2; neither is starved.
- Spurious lut_val_o pulse injected 20 cycles after reset with no issue outstanding -> err=1 and stays 1; no res_valid rises.
- rst_n pulsed low with 3 operations in flight -> all outputs return to 0 immediately. Stale lut_val_o within LUT_LAT+1 cycles after release does not set err and does not raise res_valid.

Source files
------------

// File: rtl/sqrt_lut_arbiter.sv
// Round-robin arbiter that shares one pipelined SqrtLut between NREQ requesters.
// A tag pipeline matched to the LUT latency routes each result back to its issuer.
module sqrt_lut_arbiter #(
    parameter int NREQ    = 4,
    parameter int LUT_LAT = 2,
    parameter int TAG_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*16-1:0] req_data,
    output logic [NREQ-1:0]   res_valid,
    input  logic [NREQ-1:0]   res_ready,
    output logic [NREQ*8-1:0] res_data,
    output logic [15:0]       lut_i,
    output logic              lut_val_i,
    input  logic [7:0]        lut_o,
    input  logic              lut_val_o,
    output logic              err
);
    localparam int GUARD_W = $clog2(LUT_LAT + 2);
    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(LUT_LAT + 1);

    logic [NREQ-1:0]             busy_q, busy_d;
    logic [TAG_W-1:0]            rr_q, rr_d;
    logic [15:0]                 lut_i_q, lut_i_d;
    logic                        lut_val_i_q, lut_val_i_d;
    logic [LUT_LAT:0][TAG_W-1:0] tag_q, tag_d;
    logic [LUT_LAT:0]            tag_vld_q, tag_vld_d;
    logic [NREQ-1:0]             res_valid_q, res_valid_d;
    logic [NREQ*8-1:0]           res_data_q, res_data_d;
    logic                        err_q, err_d;
    logic [GUARD_W-1:0]          guard_q, guard_d;

    logic                        grant_vld;
    logic [TAG_W-1:0]            grant_idx;
    logic [NREQ-1:0]             grant_oh;
    logic [TAG_W-1:0]            cand;
    int                          cand_sum;
    logic [TAG_W-1:0]            tag_out;
    logic                        tag_out_vld;

    // Search upward from the rr pointer, wrapping modulo NREQ; first eligible wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = '0;
        cand_sum  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum = int'(rr_q) + i;
            if (cand_sum >= NREQ) begin
                cand_sum = cand_sum - NREQ;
            end
            cand = TAG_W'(cand_sum);
            if (!grant_vld && req_valid[cand] && !busy_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            grant_oh[r] = grant_vld && (grant_idx == TAG_W'(r));
        end
    end

    assign req_ready   = rst_n ? grant_oh : '0;
    assign tag_out     = tag_q[LUT_LAT];
    assign tag_out_vld = tag_vld_q[LUT_LAT];

    always_comb begin
        busy_d      = busy_q;
        rr_d        = rr_q;
        lut_i_d     = lut_i_q;
        lut_val_i_d = grant_vld;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        tag_d       = '0;
        tag_vld_d   = '0;

        tag_d[0]     = grant_idx;
        tag_vld_d[0] = grant_vld;
        for (int s = 1; s <= LUT_LAT; s++) begin
            tag_d[s]     = tag_q[s-1];
            tag_vld_d[s] = tag_vld_q[s-1];
        end

        if (grant_vld) begin
            rr_d = (grant_idx == TAG_W'(NREQ - 1)) ? '0 : grant_idx + TAG_W'(1);
            for (int r = 0; r < NREQ; r++) begin
                if (grant_idx == TAG_W'(r)) begin
                    lut_i_d = req_data[16*r +: 16];
                end
            end
        end

        // Pop frees the slot; a single outstanding op per requester means capture never collides with it.
        for (int r = 0; r < NREQ; r++) begin
            if (res_valid_q[r] && res_ready[r]) begin
                res_valid_d[r] = 1'b0;
                busy_d[r]      = 1'b0;
            end
            if (grant_oh[r]) begin
                busy_d[r] = 1'b1;
            end
            if (lut_val_o && tag_out_vld && (tag_out == TAG_W'(r))) begin
                res_valid_d[r]        = 1'b1;
                res_data_d[8*r +: 8]  = lut_o;
            end
        end

        // The LUT has no reset, so stale outputs right after reset are not errors.
        guard_d = (guard_q == '0) ? '0 : guard_q - GUARD_W'(1);
        err_d   = err_q || ((guard_q == '0) && (lut_val_o != tag_out_vld));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rr_q        <= '0;
            lut_i_q     <= '0;
            lut_val_i_q <= 1'b0;
            tag_q       <= '0;
            tag_vld_q   <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            guard_q     <= GUARD_INIT;
        end else begin
            busy_q      <= busy_d;
            rr_q        <= rr_d;
            lut_i_q     <= lut_i_d;
            lut_val_i_q <= lut_val_i_d;
            tag_q       <= tag_d;
            tag_vld_q   <= tag_vld_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            guard_q     <= guard_d;
        end
    end

    assign lut_i     = lut_i_q;
    assign lut_val_i = lut_val_i_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sqrt_lut_arbiter.sv
// Bench for sqrt_lut_arbiter: behavioural SqrtLut with no reset, plus an in-order
// scoreboard of expected results filled at each request handshake.
module tb_sqrt_lut_arbiter;
    localparam int NREQ    = 4;
    localparam int LUT_LAT = 2;
    localparam int TAG_W   = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*16-1:0]  req_data = '0;
    logic [NREQ-1:0]     res_valid;
    logic [NREQ-1:0]     res_ready = '0;
    logic [NREQ*8-1:0]   res_data;
    logic [15:0]         lut_i;
    logic                lut_val_i;
    logic [7:0]          lut_o;
    logic                lut_val_o;
    logic                err;
    logic                inject = 1'b0;

    int                  total = 0;
    int                  bad = 0;
    int                  n_results = 0;
    int                  sb_who[$];
    logic [7:0]          sb_val[$];
    int                  grant_log[$];
    logic [NREQ-1:0]     seen = '0;
    int                  mon_who;
    logic [7:0]          mon_val;

    always #5 clk = ~clk;

    sqrt_lut_arbiter #(.NREQ(NREQ), .LUT_LAT(LUT_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .lut_i(lut_i),
        .lut_val_i(lut_val_i),
        .lut_o(lut_o),
        .lut_val_o(lut_val_o),
        .err(err)
    );

    function automatic logic [7:0] isqrt(input logic [15:0] x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return 8'(r);
    endfunction

    // SqrtLut stand-in: LUT_LAT register stages, deliberately without reset.
    logic [LUT_LAT-1:0] pv = '0;
    logic [7:0]         pd [LUT_LAT];
    always @(posedge clk) begin
        pv[0] <= lut_val_i;
        pd[0] <= isqrt(lut_i);
        for (int s = 1; s < LUT_LAT; s++) begin
            pv[s] <= pv[s-1];
            pd[s] <= pd[s-1];
        end
    end
    assign lut_val_o = pv[LUT_LAT-1] | inject;
    assign lut_o     = pd[LUT_LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rdy);
        req_valid = v;
        res_ready = rdy;
    endtask

    // Scoreboard: push on handshake, pop and compare when a new result appears.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ready_onehot0", 32'($onehot0(req_ready)), 1);
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    sb_who.push_back(r);
                    sb_val.push_back(isqrt(req_data[16*r +: 16]));
                    grant_log.push_back(r);
                end
            end
            for (int r = 0; r < NREQ; r++) begin
                if (res_valid[r] && !seen[r]) begin
                    if (sb_who.size() == 0) begin
                        checkOutput("res_unexpected", 32'(r), NREQ);
                    end else begin
                        mon_who = sb_who.pop_front();
                        mon_val = sb_val.pop_front();
                        checkOutput("res_who", 32'(r), 32'(mon_who));
                        checkOutput("res_data", 32'(res_data[8*r +: 8]), 32'(mon_val));
                        n_results++;
                    end
                    seen[r] = 1'b1;
                end
                if (res_valid[r] && res_ready[r]) begin
                    seen[r] = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rad [4];
        int          base;
        int          cnt0;
        int          cnt2;
        logic        got;

        rad[0] = 16'h0100;
        rad[1] = 16'h0400;
        rad[2] = 16'h0900;
        rad[3] = 16'h1000;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_lut_i", 32'(lut_i), 0);
        checkOutput("rst_lut_val_i", 32'(lut_val_i), 0);
        checkOutput("rst_res_valid", 32'(res_valid), 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_err", 32'(err), 0);
        nextCycle();
        rst_n = 1'b1;
        repeat (4) nextCycle();

        // All four requesters at once from rr=0
        $display("[TB] burst of four requests");
        base = n_results;
        req_data = {rad[3], rad[2], rad[1], rad[0]};
        applyStimulus(4'b1111, 4'b1111);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput("burst_lut_i", 32'(lut_i), 32'(rad[i-1]));
                checkOutput("burst_lut_val_i", 32'(lut_val_i), 1);
            end
            if (i < 4) begin
                checkOutput("burst_grant", 32'(req_ready), 1 << i);
            end
            nextCycle();
            if (i < 4) begin
                req_valid[i] = 1'b0;
            end
        end
        repeat (8) nextCycle();
        checkOutput("burst_count", 32'(n_results - base), 4);
        checkOutput("burst_sb_empty", 32'(sb_who.size()), 0);
        applyStimulus(4'b0000, 4'b0000);
        nextCycle();

        // Single request latency
        $display("[TB] single request latency");
        req_data[15:0] = 16'h0100;
        applyStimulus(4'b0001, 4'b0000);
        @(negedge clk);
        checkOutput("single_ready", 32'(req_ready), 32'h1);
        nextCycle();
        req_valid = '0;
        @(negedge clk);
        checkOutput("single_lut_val_i", 32'(lut_val_i), 1);
        checkOutput("single_lut_i", 32'(lut_i), 32'h0100);
        checkOutput("single_res_t1", 32'(res_valid), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("single_res_t2", 32'(res_valid), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("single_res_t3", 32'(res_valid), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("single_res_t4", 32'(res_valid), 32'h1);
        checkOutput("single_res_data", 32'(res_data[7:0]), 32'h10);
        checkOutput("single_err", 32'(err), 0);
        nextCycle();
        res_ready = 4'b0001;
        nextCycle();
        res_ready = 4'b0000;
        @(negedge clk);
        checkOutput("single_popped", 32'(res_valid), 0);
        nextCycle();

        // Backpressure on requester 1
        $display("[TB] backpressure on requester 1");
        req_data[31:16] = 16'h0900;
        applyStimulus(4'b0010, 4'b0000);
        @(negedge clk);
        checkOutput("bp_first_grant", 32'(req_ready), 32'h2);
        nextCycle();
        req_data[31:16] = 16'h1000;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = res_valid[1];
            if (!got) nextCycle();
        end
        checkOutput("bp_result_arrives", 32'(got), 1);
        nextCycle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("bp_no_regrant", 32'(req_ready[1]), 0);
            checkOutput("bp_hold_valid", 32'(res_valid[1]), 1);
            checkOutput("bp_hold_data", 32'(res_data[15:8]), 32'h30);
            nextCycle();
        end
        res_ready = 4'b0010;
        @(negedge clk);
        checkOutput("bp_busy_until_pop", 32'(req_ready[1]), 0);
        nextCycle();
        res_ready = 4'b0000;
        @(negedge clk);
        checkOutput("bp_popped", 32'(res_valid[1]), 0);
        checkOutput("bp_regrant", 32'(req_ready), 32'h2);
        nextCycle();
        req_valid = '0;
        repeat (5) nextCycle();
        res_ready = 4'b0010;
        repeat (2) nextCycle();
        res_ready = 4'b0000;
        @(negedge clk);
        checkOutput("bp_drained", 32'(res_valid), 0);
        checkOutput("bp_sb_empty", 32'(sb_who.size()), 0);
        nextCycle();

        // Fairness between requesters 0 and 2, rr pointer now at 2
        $display("[TB] fairness between requesters 0 and 2");
        grant_log.delete();
        req_data[15:0]  = 16'h0019;
        req_data[47:32] = 16'hFFFF;
        applyStimulus(4'b0101, 4'b1111);
        repeat (30) nextCycle();
        req_valid = '0;
        repeat (8) nextCycle();
        res_ready = '0;
        checkOutput("fair_enough_grants", 32'(grant_log.size() >= 8), 1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("fair_order", 32'(grant_log[k]), (k % 2 == 0) ? 2 : 0);
        end
        cnt0 = 0;
        cnt2 = 0;
        foreach (grant_log[k]) begin
            if (grant_log[k] == 0) cnt0++;
            if (grant_log[k] == 2) cnt2++;
        end
        checkOutput("fair_cnt0", 32'(cnt0 >= 5), 1);
        checkOutput("fair_cnt2", 32'(cnt2 >= 5), 1);
        checkOutput("fair_only_0_2", 32'(cnt0 + cnt2), 32'(grant_log.size()));
        @(negedge clk);
        checkOutput("fair_err", 32'(err), 0);
        checkOutput("fair_drained", 32'(res_valid), 0);
        nextCycle();

        // Reset with three operations in flight
        $display("[TB] reset mid-operation");
        req_data = {16'h0031, 16'h0040, 16'h0051, 16'h0064};
        applyStimulus(4'b1111, 4'b0000);
        repeat (3) nextCycle();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        checkOutput("mid_rst_req_ready", 32'(req_ready), 0);
        checkOutput("mid_rst_lut_val_i", 32'(lut_val_i), 0);
        checkOutput("mid_rst_lut_i", 32'(lut_i), 0);
        checkOutput("mid_rst_res_valid", 32'(res_valid), 0);
        checkOutput("mid_rst_res_data", res_data, 0);
        sb_who.delete();
        sb_val.delete();
        seen = '0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("stale_res_valid", 32'(res_valid), 0);
            checkOutput("stale_err", 32'(err), 0);
            nextCycle();
        end

        // Spurious LUT pulse with nothing outstanding
        $display("[TB] spurious lut_val_o pulse");
        repeat (13) nextCycle();
        inject = 1'b1;
        nextCycle();
        inject = 1'b0;
        @(negedge clk);
        checkOutput("spur_err_set", 32'(err), 1);
        checkOutput("spur_res_valid", 32'(res_valid), 0);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("spur_err_sticky", 32'(err), 1);
        checkOutput("spur_res_still_0", 32'(res_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
